mdu_iterative: RTL and testbench

Iterative multiply/divide unit for the 16-bit MIPS execute stage. It takes the same register-file operands that feed the combinational ALU and produces a 32-bit HI/LO result over multiple cycles for mult, multu, div and divu. The pipeline control stalls on `busy` and samples `hi`/`lo` when `done` pulses.

---
 rtl/mdu_iterative.sv | 157 +++++++++++++++
 tb/tb_mdu_iterative.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide share
// one 2W-bit accumulator; W CALC cycles, then one sign-fix/write-back cycle.
module mdu_iterative #(
  parameter int inst_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [inst_SIZE-1:0] in0,
  input  logic [inst_SIZE-1:0] in1,
  output logic                 busy,
  output logic                 done,
  output logic [inst_SIZE-1:0] hi,
  output logic [inst_SIZE-1:0] lo,
  output logic                 div_by_zero
);
  localparam int W     = inst_SIZE;
  localparam int CNT_W = $clog2(W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state_q, state_d;
  logic               div_op_q, div_op_d;
  logic               neg_a_q, neg_a_d;
  logic               neg_b_q, neg_b_d;
  logic [W-1:0]       opb_q, opb_d;
  logic [2*W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [W-1:0]       hi_q, hi_d;
  logic [W-1:0]       lo_q, lo_d;
  logic               dbz_q, dbz_d;

  logic               in0_neg, in1_neg;
  logic [W-1:0]       in0_mag, in1_mag;
  logic [W:0]         mul_sum;
  logic [2*W-1:0]     mul_next;
  logic [W:0]         rem_sh;
  logic               no_borrow;
  logic [2*W-1:0]     div_next;
  logic [2*W-1:0]     prod_fix;
  logic [W-1:0]       quo_fix, rem_fix;

  always_comb begin
    // Sign bits are only meaningful for the signed ops (op[0] = 1).
    in0_neg = op[0] & in0[W-1];
    in1_neg = op[0] & in1[W-1];
    in0_mag = in0_neg ? -in0 : in0;
    in1_mag = in1_neg ? -in1 : in1;

    // Multiply: the multiplier sits in the low half and is consumed LSB first
    // while the partial product shifts down into its place.
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
    mul_next = {mul_sum, acc_q[W-1:1]};

    // Divide: acc = {remainder, quotient}; the shifted remainder is W+1 bits wide.
    rem_sh    = acc_q[2*W-1:W-1];
    no_borrow = rem_sh >= {1'b0, opb_q};
    div_next  = {no_borrow ? (rem_sh[W-1:0] - opb_q) : rem_sh[W-1:0],
                 acc_q[W-2:0], no_borrow};

    prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    quo_fix  = (neg_a_q ^ neg_b_q) ? -acc_q[W-1:0] : acc_q[W-1:0];
    rem_fix  = neg_a_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

    state_d  = state_q;
    div_op_d = div_op_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = CALC;
          div_op_d = op[1];
          neg_a_d  = in0_neg;
          neg_b_d  = in1_neg;
          opb_d    = in1_mag;
          acc_d    = {{W{1'b0}}, in0_mag};
          cnt_d    = '0;
          dbz_d    = 1'b0;
          busy_d   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        acc_d = div_op_q ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = FIX;
      end
      FIX: begin
        if (div_op_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*W-1:W];
          lo_d = prod_fix[W-1:0];
        end
        // A zero magnitude divisor can only come from in1 == 0.
        dbz_d   = div_op_q && (opb_q == '0);
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      div_op_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      opb_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_op_q <= div_op_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: directed vector table, hand-written
// multi-cycle sequences, and random ops checked against an arithmetic model.
module tb_mdu_iterative;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [15:0] in0, in1;
  logic        busy, done, div_by_zero;
  logic [15:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mdu_iterative #(.inst_SIZE(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .in0(in0), .in1(in1),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] hi;
    logic [15:0] lo;
    logic        dbz;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, results as {dbz, hi, lo}.
  function automatic logic [32:0] model(input logic [1:0] mop, input logic [15:0] a,
                                        input logic [15:0] b);
    longint unsigned up;
    int sa, sb, q, r;
    logic [15:0] mag;
    sa = $signed(a);
    sb = $signed(b);
    case (mop)
      2'b00: begin
        up = longint'(a) * longint'(b);
        return {1'b0, up[31:0]};
      end
      2'b01: begin
        q = sa * sb;
        return {1'b0, q[31:0]};
      end
      2'b10: begin
        if (b == 16'h0) return {1'b1, a, 16'hFFFF};
        return {1'b0, a % b, a / b};
      end
      default: begin
        if (b == 16'h0) begin
          mag = a[15] ? 16'(-sa) : a;
          q = a[15] ? 1 : 32'h0000FFFF;
          r = a[15] ? -int'(mag) : int'(mag);
          return {1'b1, r[15:0], q[15:0]};
        end
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[15:0], q[15:0]};
      end
    endcase
  endfunction

  task automatic wait_done(output int ncyc, output int nbusy);
    ncyc  = 0;
    nbusy = 0;
    do begin
      @(negedge clk);
      ncyc++;
      if (busy) nbusy++;
    end while (!done && ncyc < 40);
  endtask

  task automatic run_op(input string name, input logic [1:0] vop, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] ehi, input logic [15:0] elo,
                        input logic edbz);
    int ncyc, nbusy;
    @(negedge clk);
    start = 1'b1; op = vop; in0 = a; in1 = b;
    @(posedge clk);
    #1;
    start = 1'b0; op = 2'($urandom); in0 = 16'($urandom); in1 = 16'($urandom);
    wait_done(ncyc, nbusy);
    check({name, "_latency"}, ncyc, 18);
    check({name, "_busy_cycles"}, nbusy, 17);
    check({name, "_hi"}, hi, ehi);
    check({name, "_lo"}, lo, elo);
    check({name, "_dbz"}, div_by_zero, edbz);
    $display("%s op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0d (exp %h %h %0d)",
             name, vop, a, b, hi, lo, div_by_zero, ehi, elo, edbz);
    @(negedge clk);
    check({name, "_done_pulse"}, done, 1'b0);
  endtask

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'h8000;
      2: return 16'hFFFF;
      3: return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ncyc, nbusy, dcount;
    logic [15:0] cap_hi, cap_lo;
    logic [32:0] exp;
    logic [1:0]  rop;
    logic [15:0] ra, rb;

    vecs[0] = '{"multu_ffff", 2'b00, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0};
    vecs[1] = '{"mult_neg3x5", 2'b01, 16'hFFFD, 16'h0005, 16'hFFFF, 16'hFFF1, 1'b0};
    vecs[2] = '{"mult_8000sq", 2'b01, 16'h8000, 16'h8000, 16'h4000, 16'h0000, 1'b0};
    vecs[3] = '{"mult_7fffx8000", 2'b01, 16'h7FFF, 16'h8000, 16'hC000, 16'h8000, 1'b0};
    vecs[4] = '{"divu_100_7", 2'b10, 16'd100, 16'd7, 16'h0002, 16'h000E, 1'b0};
    vecs[5] = '{"divu_5_9", 2'b10, 16'd5, 16'd9, 16'h0005, 16'h0000, 1'b0};
    vecs[6] = '{"div_neg7_2", 2'b11, 16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0};
    vecs[7] = '{"div_7_neg2", 2'b11, 16'h0007, 16'hFFFE, 16'h0001, 16'hFFFD, 1'b0};
    vecs[8] = '{"div_ovf", 2'b11, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0};
    vecs[9] = '{"divu_by0", 2'b10, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1};

    rst_n = 1'b0; start = 1'b0; op = 2'b00; in0 = 16'h0; in1 = 16'h0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_hi", hi, 16'h0);
    check("reset_lo", lo, 16'h0);
    check("reset_dbz", div_by_zero, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dbz);

    // Signed divide by zero: the sign fix applies to the natural result.
    run_op("div_by0_neg", 2'b11, 16'hFFF9, 16'h0000, 16'hFFF9, 16'h0001, 1'b1);

    // div_by_zero clears on the next accept edge.
    @(negedge clk);
    start = 1'b1; op = 2'b00; in0 = 16'd2; in1 = 16'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("dbz_clear_on_accept", div_by_zero, 1'b0);
    wait_done(ncyc, nbusy);
    check("dbz_clear_lo", lo, 16'd6);
    $display("dbz_clear multu 2x3 -> hi=%h lo=%h dbz=%0d", hi, lo, div_by_zero);

    // Start pulses while busy are ignored.
    @(negedge clk);
    start = 1'b1; op = 2'b00; in0 = 16'd7; in1 = 16'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    dcount = 0; cap_hi = 16'hDEAD; cap_lo = 16'hDEAD;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (done) begin
        dcount++;
        cap_hi = hi;
        cap_lo = lo;
      end
      if (k == 5 || k == 10) begin
        start = 1'b1; op = 2'b11; in0 = 16'h4321; in1 = 16'h0011;
      end else begin
        start = 1'b0;
      end
    end
    check("busy_ignore_done_count", dcount, 1);
    check("busy_ignore_hi", cap_hi, 16'h0000);
    check("busy_ignore_lo", cap_lo, 16'h003F);
    $display("busy_ignore multu 7x9 -> hi=%h lo=%h dones=%0d", cap_hi, cap_lo, dcount);

    // Back-to-back: start held high through DONE is accepted on E18.
    @(negedge clk);
    start = 1'b1; op = 2'b00; in0 = 16'h00FF; in1 = 16'h0011;
    @(posedge clk);
    #1;
    op = 2'b10; in0 = 16'd1000; in1 = 16'd33;
    wait_done(ncyc, nbusy);
    check("b2b_first_latency", ncyc, 18);
    check("b2b_first_lo", lo, 16'h10EF);
    @(negedge clk);
    check("b2b_second_busy", busy, 1'b1);
    check("b2b_second_done_low", done, 1'b0);
    start = 1'b0;
    wait_done(ncyc, nbusy);
    check("b2b_second_latency", ncyc, 17);
    check("b2b_second_hi", hi, 16'h000A);
    check("b2b_second_lo", lo, 16'h001E);
    $display("b2b divu 1000/33 -> hi=%h lo=%h", hi, lo);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1; op = 2'b10; in0 = 16'hBEEF; in1 = 16'h0003;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_busy", busy, 1'b0);
    check("midreset_done", done, 1'b0);
    check("midreset_hi", hi, 16'h0);
    check("midreset_lo", lo, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("midreset_no_done", dcount, 0);
    $display("midreset divu aborted -> hi=%h lo=%h dones_after=%0d", hi, lo, dcount);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom);
      ra  = pick_operand();
      rb  = pick_operand();
      exp = model(rop, ra, rb);
      run_op($sformatf("rand%0d", i), rop, ra, rb, exp[31:16], exp[15:0], exp[32]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
